tabla_barrido: RTL and testbench

Exhaustive-sweep sequencer for the lab's small combinational truth-table modules (3-input, 1-output function blocks). On `start` it drives every input combination in ascending binary order onto the function block and samples its output after a programmable settle time. It assembles the measured truth table and compares it with a golden table latched at start. It replaces the hand-written `#1` stimulus lists with a synthesizable, clocked self-check usable on the board.

---
 rtl/tabla_barrido.sv | 147 ++++++++++++++
 tb/tb_tabla_barrido.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tabla_barrido.sv
// Exhaustive truth-table sweeper: drives every input vector in ascending order, samples y after SETTLE+1 cycles.
// Sweep takes 2^N_IN*(SETTLE+1) busy cycles plus a DONE cycle; start is ignored unless idle.
module tabla_barrido #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   input  logic                 y,
   output logic [N_IN-1:0]      abc,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_out,
   output logic                 pass,
   output logic [N_IN:0]        err_cnt,
   output logic [N_IN-1:0]      first_fail
);
   localparam int NT = 2**N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NT-1:0]   shadow_q, shadow_d;
   logic [NT-1:0]   gold_q, gold_d;
   logic [N_IN:0]   run_err_q, run_err_d;
   logic [N_IN-1:0] run_ff_q, run_ff_d;

   logic [N_IN-1:0] abc_q, abc_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [NT-1:0]   table_q, table_d;
   logic            pass_q, pass_d;
   logic [N_IN:0]   err_cnt_q, err_cnt_d;
   logic [N_IN-1:0] first_fail_q, first_fail_d;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      shadow_d     = shadow_q;
      gold_d       = gold_q;
      run_err_d    = run_err_q;
      run_ff_d     = run_ff_q;
      done_d       = 1'b0;
      table_d      = table_q;
      pass_d       = pass_q;
      err_cnt_d    = err_cnt_q;
      first_fail_d = first_fail_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               gold_d    = expected;
               shadow_d  = '0;
               run_err_d = '0;
               run_ff_d  = '0;
               idx_d     = '0;
               cnt_d     = CNT_LOAD;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_SAMPLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_SAMPLE: begin
            shadow_d[idx_q] = y;
            if (y != gold_q[idx_q]) begin
               run_err_d = run_err_q + (N_IN+1)'(1);
               // The running count is still zero only on the first mismatch.
               if (run_err_q == '0) run_ff_d = idx_q;
            end
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + N_IN'(1);
               cnt_d   = CNT_LOAD;
               state_d = S_WAIT;
            end
         end
         default: begin
            table_d      = shadow_q;
            err_cnt_d    = run_err_q;
            first_fail_d = run_ff_q;
            pass_d       = (run_err_q == '0);
            done_d       = 1'b1;
            state_d      = S_IDLE;
         end
      endcase

      // Outputs follow the next state so abc/busy change on the same edge as the FSM.
      busy_d = (state_d == S_WAIT) || (state_d == S_SAMPLE);
      abc_d  = busy_d ? idx_d : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         shadow_q     <= '0;
         gold_q       <= '0;
         run_err_q    <= '0;
         run_ff_q     <= '0;
         abc_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         table_q      <= '0;
         pass_q       <= 1'b0;
         err_cnt_q    <= '0;
         first_fail_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         gold_q       <= gold_d;
         run_err_q    <= run_err_d;
         run_ff_q     <= run_ff_d;
         abc_q        <= abc_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         table_q      <= table_d;
         pass_q       <= pass_d;
         err_cnt_q    <= err_cnt_d;
         first_fail_q <= first_fail_d;
      end
   end

   assign abc        = abc_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign table_out  = table_q;
   assign pass       = pass_q;
   assign err_cnt    = err_cnt_q;
   assign first_fail = first_fail_q;
endmodule

// File: tb/tb_tabla_barrido.sv
// Bench for tabla_barrido: two instances (SETTLE=1 and SETTLE=3) each sweeping y = a&b | c.
// Predicted results go into a scoreboard queue at start and are compared when done pulses.
module tb_tabla_barrido;
   logic       clk = 1'b0;
   logic       reset;
   logic       start_s [2];
   logic [7:0] exp_s   [2];
   logic       y_s     [2];
   logic [2:0] abc_s   [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   logic [7:0] tbl_s   [2];
   logic       pass_s  [2];
   logic [3:0] err_s   [2];
   logic [2:0] ff_s    [2];

   typedef struct packed {
      logic [7:0] tbl;
      logic       pass;
      logic [3:0] err;
      logic [2:0] ff;
   } res_t;

   res_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   assign y_s[0] = (abc_s[0][2] & abc_s[0][1]) | abc_s[0][0];
   assign y_s[1] = (abc_s[1][2] & abc_s[1][1]) | abc_s[1][0];

   tabla_barrido #(.N_IN(3), .SETTLE(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start_s[0]), .expected(exp_s[0]), .y(y_s[0]),
      .abc(abc_s[0]), .busy(busy_s[0]), .done(done_s[0]), .table_out(tbl_s[0]),
      .pass(pass_s[0]), .err_cnt(err_s[0]), .first_fail(ff_s[0]));

   tabla_barrido #(.N_IN(3), .SETTLE(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start_s[1]), .expected(exp_s[1]), .y(y_s[1]),
      .abc(abc_s[1]), .busy(busy_s[1]), .done(done_s[1]), .table_out(tbl_s[1]),
      .pass(pass_s[1]), .err_cnt(err_s[1]), .first_fail(ff_s[1]));

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic res_t predict(input logic [7:0] gold);
      res_t       r;
      logic [7:0] diff;
      logic [2:0] v;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         v        = 3'(i);
         r.tbl[i] = (v[2] & v[1]) | v[0];
      end
      diff = r.tbl ^ gold;
      for (int i = 7; i >= 0; i--) begin
         if (diff[i]) begin
            r.err = r.err + 4'd1;
            r.ff  = 3'(i);
         end
      end
      r.pass = (diff == 8'h00);
      return r;
   endfunction

   function automatic logic [31:0] all_outs(input int u);
      return 32'({abc_s[u], busy_s[u], done_s[u], tbl_s[u], pass_s[u], err_s[u], ff_s[u]});
   endfunction

   task automatic run_sweep(input int u, input logic [7:0] gold, input bit hold, input bit chg);
      int   sl, nb, bad;
      res_t r;
      sl  = (u == 0) ? 1 : 3;
      nb  = 8 * (sl + 1);
      bad = 0;
      sb_q.push_back(predict(gold));
      @(negedge clk);
      start_s[u] = 1'b1;
      exp_s[u]   = gold;
      for (int c = 0; c < nb; c++) begin
         @(negedge clk);
         if (!hold) start_s[u] = 1'b0;
         if (chg && c == 5) exp_s[u] = 8'h00;
         if (busy_s[u] !== 1'b1 || done_s[u] !== 1'b0 || abc_s[u] !== 3'(c / (sl + 1))) bad++;
      end
      check_val("sweep_seq", 32'(bad), 32'd0);
      @(negedge clk);
      check_val("busy_fall", 32'({busy_s[u], done_s[u]}), 32'd0);
      @(negedge clk);
      start_s[u] = 1'b0;
      check_val("done_pulse", 32'(done_s[u]), 32'd1);
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd1, 32'd0);
      end else begin
         r = sb_q.pop_front();
         check_val("table_out", 32'(tbl_s[u]), 32'(r.tbl));
         check_val("pass", 32'(pass_s[u]), 32'(r.pass));
         check_val("err_cnt", 32'(err_s[u]), 32'(r.err));
         check_val("first_fail", 32'(ff_s[u]), 32'(r.ff));
         @(negedge clk);
         check_val("done_one", 32'({busy_s[u], done_s[u]}), 32'd0);
         check_val("hold_tbl", 32'(tbl_s[u]), 32'(r.tbl));
      end
   endtask

   initial begin
      int seen;
      reset = 1'b1;
      for (int u = 0; u < 2; u++) begin
         start_s[u] = 1'b0;
         exp_s[u]   = 8'h00;
      end
      #1;
      check_val("reset_u1", all_outs(0), 32'd0);
      check_val("reset_u3", all_outs(1), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      run_sweep(0, 8'hEA, 1'b0, 1'b0);
      run_sweep(0, 8'hEB, 1'b0, 1'b0);
      run_sweep(0, 8'h15, 1'b0, 1'b0);
      run_sweep(0, 8'hEA, 1'b1, 1'b1);

      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0) seen++;
      end
      check_val("no_resweep", 32'(seen), 32'd0);
      run_sweep(0, 8'hEA, 1'b0, 1'b0);

      // Abort a sweep with reset seven cycles in, away from any clock edge.
      @(negedge clk);
      start_s[0] = 1'b1;
      exp_s[0]   = 8'hEA;
      repeat (7) begin
         @(negedge clk);
         start_s[0] = 1'b0;
      end
      check_val("pre_rst_busy", 32'(busy_s[0]), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_val("mid_rst_outs", all_outs(0), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen  = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) seen++;
      end
      check_val("no_done_after_rst", 32'(seen), 32'd0);
      check_val("rst_outs_stay", all_outs(0), 32'd0);
      run_sweep(0, 8'hEA, 1'b0, 1'b0);

      run_sweep(1, 8'hEA, 1'b0, 1'b0);
      run_sweep(1, 8'hEB, 1'b0, 1'b0);

      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
